// File: rtl/dial_pkg.sv
// Shared mode/direction encodings and the wrap-or-clamp step arithmetic for the dial channels.
// Pure declarations and combinational helpers; no state.
package dial_pkg;

    localparam logic DIAL_MODE_BUTTON = 1'b0;
    localparam logic DIAL_MODE_SPIN   = 1'b1;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_t;

    // Position is carried in 32 bits so one function serves any dial width up to 32.
    function automatic logic [31:0] dial_step(
        input logic [31:0] pos,
        input logic [31:0] max_val,
        input logic        right,
        input logic        wrap
    );
        logic [31:0] nxt;
        nxt = pos;
        if (right) begin
            if (pos < max_val) begin
                nxt = pos + 32'd1;
            end else if (wrap) begin
                nxt = 32'd0;
            end
        end else begin
            if (pos != 32'd0) begin
                nxt = pos - 32'd1;
            end else if (wrap) begin
                nxt = max_val;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dial_channel.sv
// One dial channel: button-rate stepping with acceleration, or direct spinner stepping.
// Latency 1 clk (all outputs registered); inputs are sampled levels/pulses, no backpressure.
module dial_channel
    import dial_pkg::*;
#(
    parameter int                DIAL_W      = 5,
    parameter logic [DIAL_W-1:0] RESET_VAL   = '0,
    parameter int                SLOW_DIV    = 4,
    parameter int                FAST_DIV    = 1,
    parameter int                ACCEL_AFTER = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              mode,
    input  logic              wrap_en,
    input  logic              move_left,
    input  logic              move_right,
    input  logic              spin_pulse,
    input  logic              spin_dir,
    output logic [DIAL_W-1:0] dial,
    output logic              step_strobe,
    output logic              dir_out
);

    localparam int HW = $clog2(SLOW_DIV + 1);
    localparam int SW = $clog2(ACCEL_AFTER + 1);
    localparam logic [DIAL_W-1:0] DIAL_MAX = '1;

    logic [DIAL_W-1:0] dial_q, dial_d;
    logic              strobe_q, strobe_d;
    logic              dir_q, dir_d;
    logic              mode_q, mode_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [SW-1:0]     stepc_q, stepc_d;
    dir_t              prev_q, prev_d;

    dir_t          cmd;
    dir_t          prev_eff;
    logic [HW-1:0] hold_eff;
    logic [SW-1:0] stepc_eff;
    logic          do_step;
    logic          step_right;
    int            period;
    logic [31:0]   nxt;

    always_comb begin
        dial_d     = dial_q;
        strobe_d   = 1'b0;
        dir_d      = dir_q;
        mode_d     = mode;
        do_step    = 1'b0;
        step_right = 1'b0;
        period     = SLOW_DIV;
        nxt        = 32'(dial_q);

        if (move_right && !move_left) begin
            cmd = DIR_RIGHT;
        end else if (move_left && !move_right) begin
            cmd = DIR_LEFT;
        end else begin
            cmd = DIR_NONE;
        end

        // A mode change forgets the hold history so a held button re-arms as a fresh press.
        if (mode != mode_q) begin
            prev_eff  = DIR_NONE;
            hold_eff  = '0;
            stepc_eff = '0;
        end else begin
            prev_eff  = prev_q;
            hold_eff  = hold_q;
            stepc_eff = stepc_q;
        end

        hold_d  = hold_eff;
        stepc_d = stepc_eff;
        prev_d  = prev_eff;

        if (mode == DIAL_MODE_SPIN) begin
            hold_d  = '0;
            stepc_d = '0;
            prev_d  = DIR_NONE;
            if (spin_pulse) begin
                do_step    = 1'b1;
                step_right = spin_dir;
            end
        end else if (ce) begin
            period = (32'(stepc_eff) >= ACCEL_AFTER) ? FAST_DIV : SLOW_DIV;
            if (cmd == DIR_NONE) begin
                hold_d  = '0;
                stepc_d = '0;
                prev_d  = DIR_NONE;
            end else if (cmd != prev_eff) begin
                do_step    = 1'b1;
                step_right = (cmd == DIR_RIGHT);
                hold_d     = '0;
                stepc_d    = SW'(1);
                prev_d     = cmd;
            end else if (32'(hold_eff) + 32'd1 >= 32'(period)) begin
                do_step    = 1'b1;
                step_right = (cmd == DIR_RIGHT);
                hold_d     = '0;
                if (32'(stepc_eff) < ACCEL_AFTER) begin
                    stepc_d = stepc_eff + SW'(1);
                end
            end else begin
                hold_d = hold_eff + HW'(1);
            end
        end

        // A clamped step still records its direction but is not a visible change.
        if (do_step) begin
            nxt   = dial_step(32'(dial_q), 32'(DIAL_MAX), step_right, wrap_en);
            dir_d = step_right;
            if (nxt != 32'(dial_q)) begin
                dial_d   = nxt[DIAL_W-1:0];
                strobe_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dial_q   <= RESET_VAL;
            strobe_q <= 1'b0;
            dir_q    <= 1'b0;
            mode_q   <= DIAL_MODE_BUTTON;
            hold_q   <= '0;
            stepc_q  <= '0;
            prev_q   <= DIR_NONE;
        end else begin
            dial_q   <= dial_d;
            strobe_q <= strobe_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
            hold_q   <= hold_d;
            stepc_q  <= stepc_d;
            prev_q   <= prev_d;
        end
    end

    assign dial        = dial_q;
    assign step_strobe = strobe_q;
    assign dir_out     = dir_q;

endmodule

// File: rtl/multi_dial.sv
// Multi-channel dial position generator: NUM_CH independent dial_channel instances, packed outputs.
// Latency 1 clk (registered outputs); no backpressure, every channel acts in the same cycle.
module multi_dial
    import dial_pkg::*;
#(
    parameter int                NUM_CH      = 2,
    parameter int                DIAL_W      = 5,
    parameter logic [DIAL_W-1:0] RESET_VAL   = '0,
    parameter int                SLOW_DIV    = 4,
    parameter int                FAST_DIV    = 1,
    parameter int                ACCEL_AFTER = 4
) (
    input  logic                     clk,
    input  logic                     RESET_N,
    input  logic                     ce,
    input  logic [NUM_CH-1:0]        mode,
    input  logic [NUM_CH-1:0]        wrap_en,
    input  logic [NUM_CH-1:0]        move_left,
    input  logic [NUM_CH-1:0]        move_right,
    input  logic [NUM_CH-1:0]        spin_pulse,
    input  logic [NUM_CH-1:0]        spin_dir,
    output logic [NUM_CH*DIAL_W-1:0] dial_out,
    output logic [NUM_CH-1:0]        step_strobe,
    output logic [NUM_CH-1:0]        dir_out
);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        dial_channel #(
            .DIAL_W      (DIAL_W),
            .RESET_VAL   (RESET_VAL),
            .SLOW_DIV    (SLOW_DIV),
            .FAST_DIV    (FAST_DIV),
            .ACCEL_AFTER (ACCEL_AFTER)
        ) u_ch (
            .clk         (clk),
            .rst_n       (RESET_N),
            .ce          (ce),
            .mode        (mode[k]),
            .wrap_en     (wrap_en[k]),
            .move_left   (move_left[k]),
            .move_right  (move_right[k]),
            .spin_pulse  (spin_pulse[k]),
            .spin_dir    (spin_dir[k]),
            .dial        (dial_out[k*DIAL_W +: DIAL_W]),
            .step_strobe (step_strobe[k]),
            .dir_out     (dir_out[k])
        );
    end

endmodule

// File: tb/tb_multi_dial.sv
// Directed bench for multi_dial: a step scoreboard checked on every strobe, plus per-cycle strobe/position checks.
module tb_multi_dial;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic [1:0] mode, wrap_en, move_left, move_right, spin_pulse, spin_dir;
    logic [9:0] dial_out;
    logic [1:0] step_strobe, dir_out;

    int checks = 0;
    int errors = 0;

    logic [4:0] pos [2];
    logic [5:0] q0 [$];
    logic [5:0] q1 [$];

    multi_dial #(
        .NUM_CH      (2),
        .DIAL_W      (5),
        .RESET_VAL   (5'd10),
        .SLOW_DIV    (4),
        .FAST_DIV    (1),
        .ACCEL_AFTER (4)
    ) dut (
        .clk         (clk),
        .RESET_N     (rst_n),
        .ce          (ce),
        .mode        (mode),
        .wrap_en     (wrap_en),
        .move_left   (move_left),
        .move_right  (move_right),
        .spin_pulse  (spin_pulse),
        .spin_dir    (spin_dir),
        .dial_out    (dial_out),
        .step_strobe (step_strobe),
        .dir_out     (dir_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] dial_ch(input int k);
        return dial_out[k*5 +: 5];
    endfunction

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference step: wrap modulo 32 or clamp at 0/31; pushes only visible changes.
    task automatic expect_step(input int ch, input logic right);
        logic [4:0] p;
        logic       moved;
        p = pos[ch];
        moved = 1'b1;
        if (right) begin
            if (p == 5'd31) begin
                if (wrap_en[ch]) p = 5'd0; else moved = 1'b0;
            end else p = p + 5'd1;
        end else begin
            if (p == 5'd0) begin
                if (wrap_en[ch]) p = 5'd31; else moved = 1'b0;
            end else p = p - 5'd1;
        end
        pos[ch] = p;
        if (moved) begin
            if (ch == 0) q0.push_back({right, p});
            else         q1.push_back({right, p});
        end
    endtask

    task automatic ce_cyc(input logic [1:0] exp_s, input string tag);
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        check(32'(step_strobe), 32'(exp_s), tag);
    endtask

    task automatic spin_to(input int ch, input logic [4:0] target);
        logic d;
        while (pos[ch] != target) begin
            d = (target > pos[ch]);
            spin_dir[ch]   = d;
            spin_pulse[ch] = 1'b1;
            expect_step(ch, d);
            @(negedge clk);
            spin_pulse[ch] = 1'b0;
        end
        @(negedge clk);
    endtask

    // Scoreboard: every strobe must match the next expected step of that channel.
    always @(negedge clk) begin
        if (rst_n) begin
            if (step_strobe[0]) begin
                if (q0.size() == 0) begin
                    check(32'd1, 32'd0, "ch0_unexpected_strobe");
                end else begin
                    logic [5:0] e;
                    e = q0.pop_front();
                    check(32'(dial_ch(0)), 32'(e[4:0]), "ch0_step_pos");
                    check(32'(dir_out[0]), 32'(e[5]), "ch0_step_dir");
                end
            end
            if (step_strobe[1]) begin
                if (q1.size() == 0) begin
                    check(32'd1, 32'd0, "ch1_unexpected_strobe");
                end else begin
                    logic [5:0] e;
                    e = q1.pop_front();
                    check(32'(dial_ch(1)), 32'(e[4:0]), "ch1_step_pos");
                    check(32'(dir_out[1]), 32'(e[5]), "ch1_step_dir");
                end
            end
        end
    end

    initial begin
        logic       st;
        logic [4:0] spin_exp [4];
        logic       spin_d   [4];

        rst_n = 1'b0; ce = 1'b0;
        mode = 2'b00; wrap_en = 2'b11;
        move_left = 2'b00; move_right = 2'b00;
        spin_pulse = 2'b00; spin_dir = 2'b00;
        pos[0] = 5'd10; pos[1] = 5'd10;

        // Reset
        @(negedge clk);
        @(negedge clk);
        check(32'(dial_out), 32'({5'd10, 5'd10}), "reset_dial");
        check(32'(step_strobe), 32'd0, "reset_strobe");
        check(32'(dir_out), 32'd0, "reset_dir");
        rst_n = 1'b1;
        @(negedge clk);

        // Acceleration: steps on ce 1,5,9,13,14,15,16
        move_right[0] = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            st = (i == 1 || i == 5 || i == 9 || i >= 13);
            if (st) expect_step(0, 1'b1);
            ce_cyc({1'b0, st}, "accel_strobe");
        end
        move_right[0] = 1'b0;
        ce_cyc(2'b00, "accel_release");
        check(32'(dial_ch(0)), 32'd17, "accel_final");

        // Wrap on ch0 at max
        mode[0] = 1'b1;
        spin_to(0, 5'd31);
        mode[0] = 1'b0;
        @(negedge clk);
        move_right[0] = 1'b1;
        expect_step(0, 1'b1);
        ce_cyc(2'b01, "wrap_high_strobe");
        check(32'(dial_ch(0)), 32'd0, "wrap_high_pos");
        move_right[0] = 1'b0;
        ce_cyc(2'b00, "wrap_release");

        // Reversal through both-pressed: new direction steps at once and restarts slow cadence
        move_right[0] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            st = (i == 1 || i == 5);
            if (st) expect_step(0, 1'b1);
            ce_cyc({1'b0, st}, "rev_right_strobe");
        end
        move_left[0] = 1'b1;
        for (int i = 1; i <= 3; i++) ce_cyc(2'b00, "rev_both_strobe");
        check(32'(dial_ch(0)), 32'd2, "rev_both_pos");
        move_right[0] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            st = (i == 1 || i == 5);
            if (st) expect_step(0, 1'b0);
            ce_cyc({1'b0, st}, "rev_left_strobe");
        end
        move_left[0] = 1'b0;
        ce_cyc(2'b00, "rev_release");
        check(32'(dial_ch(0)), 32'd0, "rev_final");

        // Saturation on ch1
        wrap_en[1] = 1'b0;
        mode[1] = 1'b1;
        spin_to(1, 5'd0);
        mode[1] = 1'b0;
        move_left[1] = 1'b1;
        expect_step(1, 1'b0);
        ce_cyc(2'b00, "clamp_low_strobe");
        check(32'(dial_ch(1)), 32'd0, "clamp_low_pos");
        move_left[1] = 1'b0;
        ce_cyc(2'b00, "clamp_low_release");
        wrap_en[1] = 1'b1;
        move_left[1] = 1'b1;
        expect_step(1, 1'b0);
        ce_cyc(2'b10, "wrap_low_strobe");
        move_left[1] = 1'b0;
        ce_cyc(2'b00, "wrap_low_release");
        check(32'(dir_out[1]), 32'd0, "wrap_low_dir");
        wrap_en[1] = 1'b0;
        move_right[1] = 1'b1;
        expect_step(1, 1'b1);
        ce_cyc(2'b00, "clamp_high_strobe");
        check(32'(dial_ch(1)), 32'd31, "clamp_high_pos");
        check(32'(dir_out[1]), 32'd1, "clamp_high_dir");
        move_right[1] = 1'b0;
        ce_cyc(2'b00, "clamp_high_release");

        // Spinner on ch1 with move_right held and ce pulsing in the gaps
        mode[1] = 1'b1;
        spin_to(1, 5'd0);
        move_right[1] = 1'b1;
        spin_exp[0] = 5'd1; spin_exp[1] = 5'd2; spin_exp[2] = 5'd3; spin_exp[3] = 5'd2;
        spin_d[0] = 1'b1; spin_d[1] = 1'b1; spin_d[2] = 1'b1; spin_d[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            spin_dir[1]   = spin_d[i];
            spin_pulse[1] = 1'b1;
            expect_step(1, spin_d[i]);
            @(negedge clk);
            spin_pulse[1] = 1'b0;
            check(32'(dial_ch(1)), 32'(spin_exp[i]), "spin_pos");
            check(32'(step_strobe[1]), 32'd1, "spin_strobe");
            ce_cyc(2'b00, "spin_gap_strobe");
            check(32'(dial_ch(1)), 32'(spin_exp[i]), "spin_gap_pos");
        end
        move_right[1] = 1'b0;

        // Reset mid-hold, then a fresh press with slow cadence
        move_right[0] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            st = (i == 1 || i == 5);
            if (st) expect_step(0, 1'b1);
            ce_cyc({1'b0, st}, "hold_pre_reset_strobe");
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check(32'(dial_out), 32'({5'd10, 5'd10}), "midhold_reset_dial");
        check(32'(step_strobe), 32'd0, "midhold_reset_strobe");
        check(32'(dir_out), 32'd0, "midhold_reset_dir");
        pos[0] = 5'd10; pos[1] = 5'd10;
        for (int i = 1; i <= 5; i++) begin
            st = (i == 1 || i == 5);
            if (st) expect_step(0, 1'b1);
            ce_cyc({1'b0, st}, "post_reset_strobe");
        end

        // Mode 0->1->0 while holding: re-armed as a new press
        mode[0] = 1'b1;
        @(negedge clk);
        mode[0] = 1'b0;
        expect_step(0, 1'b1);
        ce_cyc(2'b01, "mode_rearm_strobe");
        move_right[0] = 1'b0;
        ce_cyc(2'b00, "mode_rearm_release");
        check(32'(dial_ch(0)), 32'd13, "mode_rearm_pos");

        // Simultaneous events on both channels
        mode[1] = 1'b0;
        move_right[0] = 1'b1;
        move_left[1]  = 1'b1;
        expect_step(0, 1'b1);
        expect_step(1, 1'b0);
        ce_cyc(2'b11, "dual_strobe");
        move_right[0] = 1'b0;
        move_left[1]  = 1'b0;
        ce_cyc(2'b00, "dual_release");
        check(32'(dial_out), 32'({5'd9, 5'd14}), "dual_pos");

        check(32'(q0.size()), 32'd0, "ch0_missing_steps");
        check(32'(q1.size()), 32'd0, "ch1_missing_steps");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
